xor3_parity_accum: RTL and testbench

- Downstream consumer of the 3-input XOR parity stage.
- Folds a stream of 3-bit beats into one parity bit per frame: each accepted beat's 3-input XOR is accumulated across the frame.
- At frame end, compares the accumulated parity against a supplied expected parity bit and presents the result on a valid/ready output.
- Sits between the parity datapath and the frame-level error reporting logic.

---
 rtl/xor3_parity_accum.sv | 152 +++++++++++++++
 tb/tb_xor3_parity_accum.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/xor3_parity_accum.sv
// xor3_parity_accum
//   Folds a stream of 3-bit beats into a single parity bit per frame. Each
//   accepted beat contributes the XOR of its three bits. When the frame closes,
//   the accumulated parity is compared with the expected parity bit, and the
//   result is held on a valid/ready output until it is consumed.
//
//   A frame closes on one of two conditions:
//     - an accepted beat with in_last set (normal close), or
//     - MAX_BEATS beats accepted without in_last (overflow close).
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset; discards any frame in progress
//   in_valid   : a beat is present
//   in_ready   : a beat can be accepted (low only while a result is held)
//   in_bits    : beat data {a,b,c}
//   in_last    : final beat of the frame
//   par_in     : expected frame parity, sampled only on the accepted last beat
//   out_valid  : a frame result is present
//   out_ready  : the result is consumed
//   out_parity : accumulated frame parity
//   out_err    : parity mismatch or overflow
//   out_ovf    : the frame reached MAX_BEATS without in_last
//   out_count  : number of beats in the frame
module xor3_parity_accum #(
  parameter int MAX_BEATS = 16,
  parameter int ODD       = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_bits,
  input  logic                           in_last,
  input  logic                           par_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_parity,
  output logic                           out_err,
  output logic                           out_ovf,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_count
);

  localparam int   CW      = $clog2(MAX_BEATS + 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            parity_q, parity_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            beat_x;
  logic            acc_new;
  logic [CW-1:0]   cnt_new;
  logic            hit_max;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign beat_x   = in_bits[2] ^ in_bits[1] ^ in_bits[0];

  // The first beat of a frame seeds from the parity sense instead of the
  // running accumulator, so no separate clear cycle is needed between frames.
  assign acc_new  = (state_q == IDLE) ? (ODD_BIT ^ beat_x) : (acc_q ^ beat_x);
  assign cnt_new  = (state_q == IDLE) ? CW'(1) : (cnt_q + CW'(1));
  assign hit_max  = (cnt_new == CW'(MAX_BEATS));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    parity_d = parity_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    count_d  = count_q;

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          if (in_last || hit_max) begin
            // in_last takes priority: a last beat at MAX_BEATS is a normal close.
            state_d  = HOLD;
            valid_d  = 1'b1;
            parity_d = acc_new;
            count_d  = cnt_new;
            ovf_d    = !in_last;
            err_d    = in_last ? (acc_new ^ par_in) : 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = IDLE;
          acc_d    = ODD_BIT;
          cnt_d    = '0;
          valid_d  = 1'b0;
          parity_d = 1'b0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          count_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= ODD_BIT;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      parity_q <= parity_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_parity = parity_q;
  assign out_err    = err_q;
  assign out_ovf    = ovf_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_xor3_parity_accum.sv
// Directed bench for xor3_parity_accum. dut0 runs with MAX_BEATS=4 and even
// parity; dut1 runs with the default MAX_BEATS and odd parity.
module tb_xor3_parity_accum;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, in_last, par_in;
  logic [2:0] in_bits;
  logic       out_valid, out_ready, out_parity, out_err, out_ovf;
  logic [2:0] out_count;

  logic       in1_valid, in1_ready, in1_last, par1_in;
  logic [2:0] in1_bits;
  logic       out1_valid, out1_ready, out1_parity, out1_err, out1_ovf;
  logic [4:0] out1_count;

  int unsigned tests;
  int unsigned failed;
  logic [7:0]  exp_tt;

  xor3_parity_accum #(.MAX_BEATS(4), .ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .in_last(in_last), .par_in(par_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_err(out_err), .out_ovf(out_ovf), .out_count(out_count)
  );

  xor3_parity_accum #(.MAX_BEATS(16), .ODD(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in1_valid), .in_ready(in1_ready), .in_bits(in1_bits),
    .in_last(in1_last), .par_in(par1_in),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_parity(out1_parity),
    .out_err(out1_err), .out_ovf(out1_ovf), .out_count(out1_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full dut0 output bundle plus in_ready.
  task automatic chk0(input string tag, input logic v, input logic p, input logic e,
                      input logic o, input logic [2:0] c, input logic rdy);
    chk({tag, ".valid"},  32'(out_valid),  32'(v));
    chk({tag, ".parity"}, 32'(out_parity), 32'(p));
    chk({tag, ".err"},    32'(out_err),    32'(e));
    chk({tag, ".ovf"},    32'(out_ovf),    32'(o));
    chk({tag, ".count"},  32'(out_count),  32'(c));
    chk({tag, ".ready"},  32'(in_ready),   32'(rdy));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    exp_tt    = 8'b1001_0110;  // parity of 0..7, bit i = parity(i)
    rst_n     = 1'b0;
    in_valid  = 1'b0; in_bits  = 3'd0; in_last  = 1'b0; par_in  = 1'b0; out_ready  = 1'b1;
    in1_valid = 1'b0; in1_bits = 3'd0; in1_last = 1'b0; par1_in = 1'b0; out1_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk0("reset", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("reset1.valid", 32'(out1_valid), 32'd0);
    chk("reset1.count", 32'(out1_count), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Truth table: single-beat frames
    for (int unsigned v = 0; v < 8; v++) begin
      in_valid = 1'b1; in_bits = 3'(v); in_last = 1'b1; par_in = 1'b0; out_ready = 1'b1;
      tick();
      chk0($sformatf("tt%0d", v), 1'b1, exp_tt[v], exp_tt[v], 1'b0, 3'd1, 1'b0);
      in_valid = 1'b0;
      tick();
      chk($sformatf("tt%0d.release", v), 32'(out_valid), 32'd0);
    end

    // Multi-beat frames with idle gaps, par_in = 0 then 1
    for (int unsigned r = 0; r < 2; r++) begin
      in_valid = 1'b1; in_bits = 3'b001; in_last = 1'b0; tick();
      in_valid = 1'b0; tick(); tick();
      in_valid = 1'b1; in_bits = 3'b011; tick();
      in_valid = 1'b0; tick(); tick();
      chk($sformatf("multi%0d.pre", r), 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_bits = 3'b111; in_last = 1'b1; par_in = 1'(r); tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk0($sformatf("multi%0d", r), 1'b1, 1'b0, 1'(r), 1'b0, 3'd3, 1'b0);
      tick();
      chk($sformatf("multi%0d.release", r), 32'(out_valid), 32'd0);
    end

    // Overflow at MAX_BEATS=4, then backpressure with a pending beat
    out_ready = 1'b0; par_in = 1'b1;
    for (int unsigned b = 0; b < 4; b++) begin
      in_valid = 1'b1; in_bits = 3'b001; in_last = 1'b0; tick();
    end
    chk0("ovf", 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    in_bits = 3'b010; in_last = 1'b1; par_in = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      in_bits = (k[0]) ? 3'b010 : 3'b110;
      tick();
      chk0($sformatf("bp%0d", k), 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
    end
    in_bits = 3'b010;
    out_ready = 1'b1;
    tick();
    chk0("bp.release", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    // Pending beat is accepted only now: a fresh single-beat frame.
    tick();
    chk0("pending", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = 3'b001; in_last = 1'b1; par_in = 1'b0; tick();
    in_valid = 1'b0;
    chk("hold.valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk0("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Reset mid-frame after two beats discards the frame
    in_valid = 1'b1; in_bits = 3'b001; in_last = 1'b0; tick();
    in_bits = 3'b010; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk0("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    chk("midrst.noresult", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_bits = 3'b100; in_last = 1'b1; par_in = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk0("after_rst", 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();

    // Odd parity sense on dut1
    in1_valid = 1'b1; in1_bits = 3'b000; in1_last = 1'b1; par1_in = 1'b1; tick();
    in1_valid = 1'b0;
    chk("odd.valid",  32'(out1_valid),  32'd1);
    chk("odd.parity", 32'(out1_parity), 32'd1);
    chk("odd.err",    32'(out1_err),    32'd0);
    chk("odd.ovf",    32'(out1_ovf),    32'd0);
    chk("odd.count",  32'(out1_count),  32'd1);
    tick();
    chk("odd.release", 32'(out1_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
